// File: rtl/mem_arbiter_if.sv
// Fetch / load-store / shared-memory bundle of the memory arbiter.
// The master side is the environment (requesters plus memory); the slave is the arbiter.
interface mem_arbiter_if;
    logic        i_pc_rd;
    logic [15:0] i_pc_addr;
    logic        o_pc_waitreq;
    logic        o_pc_rdvalid;
    logic [15:0] o_pc_rddata;

    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_addr;
    logic [15:0] i_ldst_wrdata;
    logic        o_ldst_waitreq;
    logic        o_ldst_rdvalid;
    logic [15:0] o_ldst_rddata;

    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wrdata;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] i_mem_rddata;

    modport master (
        output i_pc_rd, i_pc_addr,
        output i_ldst_rd, i_ldst_wr,
        output i_ldst_addr, i_ldst_wrdata,
        output i_mem_rddata,
        input  o_pc_waitreq, o_pc_rdvalid,
        input  o_pc_rddata,
        input  o_ldst_waitreq, o_ldst_rdvalid,
        input  o_ldst_rddata,
        input  o_mem_addr, o_mem_wrdata,
        input  o_mem_rd, o_mem_wr
    );

    modport slave (
        input  i_pc_rd, i_pc_addr,
        input  i_ldst_rd, i_ldst_wr,
        input  i_ldst_addr, i_ldst_wrdata,
        input  i_mem_rddata,
        output o_pc_waitreq, o_pc_rdvalid,
        output o_pc_rddata,
        output o_ldst_waitreq, o_ldst_rdvalid,
        output o_ldst_rddata,
        output o_mem_addr, o_mem_wrdata,
        output o_mem_rd, o_mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between fetch and load/store.
// Load/store has priority unless fetch has been starved for STARVE_LIM cycles.
module mem_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [15:0]  o_conflict_cnt
);
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_PC,
        TAG_LD
    } tag_e;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    tag_e        r_tag;
    logic [3:0]  r_starve;
    logic [15:0] r_conflict;

    logic w_fetch;
    logic w_ldst;
    logic w_ld_wr;
    logic w_ld_rd;
    logic w_starved;
    logic w_gnt_pc;
    logic w_gnt_ld;

    // Simultaneous rd and wr is treated as a store.
    assign w_fetch   = bus.i_pc_rd;
    assign w_ld_wr   = bus.i_ldst_wr;
    assign w_ld_rd   = bus.i_ldst_rd & ~bus.i_ldst_wr;
    assign w_ldst    = w_ld_rd | w_ld_wr;
    assign w_starved = (r_starve >= LIM);

    assign w_gnt_pc = w_fetch & (~w_ldst | w_starved);
    assign w_gnt_ld = w_ldst & ~w_gnt_pc;

    assign bus.o_pc_waitreq   = w_fetch & ~w_gnt_pc;
    assign bus.o_ldst_waitreq = w_ldst & ~w_gnt_ld;

    assign bus.o_pc_rdvalid   = (r_tag == TAG_PC);
    assign bus.o_ldst_rdvalid = (r_tag == TAG_LD);
    assign bus.o_pc_rddata    = bus.i_mem_rddata;
    assign bus.o_ldst_rddata  = bus.i_mem_rddata;
    assign o_conflict_cnt     = r_conflict;

    always_comb begin
        bus.o_mem_addr   = '0;
        bus.o_mem_wrdata = '0;
        bus.o_mem_rd     = 1'b0;
        bus.o_mem_wr     = 1'b0;
        unique case (1'b1)
            w_gnt_pc: begin
                bus.o_mem_addr = bus.i_pc_addr;
                bus.o_mem_rd   = 1'b1;
            end
            w_gnt_ld: begin
                bus.o_mem_addr   = bus.i_ldst_addr;
                bus.o_mem_wrdata = bus.i_ldst_wrdata;
                bus.o_mem_rd     = w_ld_rd;
                bus.o_mem_wr     = w_ld_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag      <= TAG_NONE;
            r_starve   <= 4'd0;
            r_conflict <= 16'd0;
        end else begin
            if (w_fetch & ~w_gnt_pc) begin
                if (r_starve != 4'hF)
                    r_starve <= r_starve + 4'd1;
            end else begin
                r_starve <= 4'd0;
            end

            if (w_fetch & w_ldst & (r_conflict != 16'hFFFF))
                r_conflict <= r_conflict + 16'd1;

            // Tag the granted read so its data is flagged next cycle.
            unique case (1'b1)
                w_gnt_pc:           r_tag <= TAG_PC;
                (w_gnt_ld & w_ld_rd): r_tag <= TAG_LD;
                default:            r_tag <= TAG_NONE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_mem_arbiter;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] conflict_cnt;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIM(LIM)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .o_conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ram [0:65535];

    always @(posedge clk) begin
        if (bus.o_mem_wr)
            ram[bus.o_mem_addr] <= bus.o_mem_wrdata;
        if (bus.o_mem_rd)
            bus.i_mem_rddata <= ram[bus.o_mem_addr];
    end

    // Reference model state
    int          m_starve;
    int          m_conf;
    bit          m_pc_v;
    bit          m_ld_v;
    logic [15:0] m_data;
    logic [15:0] m_wr [int];

    function automatic logic [15:0] seed(int a);
        return 16'(a * 37) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] m_mem(logic [15:0] a);
        if (m_wr.exists(int'(a)))
            return m_wr[int'(a)];
        return seed(int'(a));
    endfunction

    // 0 = none, 1 = fetch, 2 = ldst
    function automatic int exp_grant();
        bit f;
        bit l;
        f = bus.i_pc_rd;
        l = bus.i_ldst_rd | bus.i_ldst_wr;
        if (f && (!l || m_starve >= LIM))
            return 1;
        if (l)
            return 2;
        return 0;
    endfunction

    task automatic model_clear();
        m_starve = 0;
        m_conf   = 0;
        m_pc_v   = 0;
        m_ld_v   = 0;
    endtask

    task automatic drive(bit rst, bit prd, logic [15:0] pa,
                         bit lrd, bit lwr, logic [15:0] la,
                         logic [15:0] ld);
        @(negedge clk);
        reset             = rst;
        bus.i_pc_rd       = prd;
        bus.i_pc_addr     = pa;
        bus.i_ldst_rd     = lrd;
        bus.i_ldst_wr     = lwr;
        bus.i_ldst_addr   = la;
        bus.i_ldst_wrdata = ld;
        if (!rst)
            model_clear();
        #1;
    endtask

    task automatic tick();
        int  g;
        bit  f;
        bit  l;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            f = bus.i_pc_rd;
            l = bus.i_ldst_rd | bus.i_ldst_wr;
            g = exp_grant();
            if (f && l && m_conf < 65535)
                m_conf++;
            if (f && g != 1)
                m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else
                m_starve = 0;
            m_pc_v = (g == 1);
            m_ld_v = (g == 2) && !bus.i_ldst_wr;
            if (g == 1)
                m_data = m_mem(bus.i_pc_addr);
            else if (g == 2)
                m_data = m_mem(bus.i_ldst_addr);
            if (g == 2 && bus.i_ldst_wr)
                m_wr[int'(bus.i_ldst_addr)] = bus.i_ldst_wrdata;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 1, 16'h1234, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_pc_rdvalid !== 1'b0 || bus.o_ldst_rdvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rdvalid got pc=%b ld=%b want 0 0",
                     bus.o_pc_rdvalid, bus.o_ldst_rdvalid);
        end
        n_tests++;
        if (conflict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_conflict got %h want 0000", conflict_cnt);
        end
        n_tests++;
        if (bus.o_mem_rd !== 1'b1 || bus.o_mem_addr !== 16'h1234
            || bus.o_pc_waitreq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_comb got rd=%b addr=%h wq=%b want 1 1234 0",
                     bus.o_mem_rd, bus.o_mem_addr, bus.o_pc_waitreq);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_pc_rdvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_rdvalid got %b want 0",
                     bus.o_pc_rdvalid);
        end
        tick();
    endtask

    task automatic test_fetch_stream();
        logic [15:0] a;
        for (int i = 0; i < 5; i++) begin
            a = 16'h0010 + 16'(i);
            if (i < 4)
                drive(1, 1, a, 0, 0, 0, 0);
            else
                drive(1, 0, 0, 0, 0, 0, 0);
            if (i < 4) begin
                n_tests++;
                if (bus.o_mem_rd !== 1'b1 || bus.o_mem_addr !== a
                    || bus.o_pc_waitreq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_grant[%0d] rd=%b addr=%h wq=%b want 1 %h 0",
                             i, bus.o_mem_rd, bus.o_mem_addr,
                             bus.o_pc_waitreq, a);
                end
            end
            if (i > 0) begin
                n_tests++;
                if (bus.o_pc_rdvalid !== 1'b1
                    || bus.o_pc_rddata !== m_mem(a - 16'd1)) begin
                    n_fail++;
                    $display("FAIL fetch_data[%0d] v=%b d=%h want 1 %h",
                             i, bus.o_pc_rdvalid, bus.o_pc_rddata,
                             m_mem(a - 16'd1));
                end
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_pc_rdvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse got %b want 0", bus.o_pc_rdvalid);
        end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        drive(1, 1, 16'h0020, 1, 0, 16'h0100, 0);
        n_tests++;
        if (bus.o_mem_addr !== 16'h0100 || bus.o_pc_waitreq !== 1'b1
            || bus.o_ldst_waitreq !== 1'b0 || bus.o_mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_grant addr=%h pwq=%b lwq=%b want 0100 1 0",
                     bus.o_mem_addr, bus.o_pc_waitreq, bus.o_ldst_waitreq);
        end
        tick();
        drive(1, 1, 16'h0020, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_ldst_rdvalid !== 1'b1
            || bus.o_ldst_rddata !== m_mem(16'h0100)) begin
            n_fail++;
            $display("FAIL conflict_ld_data v=%b d=%h want 1 %h",
                     bus.o_ldst_rdvalid, bus.o_ldst_rddata, m_mem(16'h0100));
        end
        n_tests++;
        if (bus.o_mem_addr !== 16'h0020 || bus.o_pc_waitreq !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_fetch_next addr=%h wq=%b want 0020 0",
                     bus.o_mem_addr, bus.o_pc_waitreq);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_pc_rdvalid !== 1'b1
            || bus.o_pc_rddata !== m_mem(16'h0020)) begin
            n_fail++;
            $display("FAIL conflict_pc_data v=%b d=%h want 1 %h",
                     bus.o_pc_rdvalid, bus.o_pc_rddata, m_mem(16'h0020));
        end
        tick();
    endtask

    task automatic test_starve();
        int exp_g [6] = '{2, 2, 2, 1, 2, 2};
        int got;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 16'h0030, 1, 0, 16'h0300, 0);
            got = (bus.o_mem_addr == 16'h0030) ? 1 : 2;
            n_tests++;
            if (got != exp_g[i] || bus.o_mem_rd !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_seq[%0d] got %0d want %0d",
                         i, got, exp_g[i]);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (conflict_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL starve_conflict got %0d want 6", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_write();
        drive(1, 0, 0, 1, 1, 16'h0040, 16'hBEEF);
        n_tests++;
        if (bus.o_mem_wr !== 1'b1 || bus.o_mem_rd !== 1'b0
            || bus.o_mem_addr !== 16'h0040
            || bus.o_mem_wrdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_strobe wr=%b rd=%b a=%h d=%h want 1 0 0040 beef",
                     bus.o_mem_wr, bus.o_mem_rd, bus.o_mem_addr,
                     bus.o_mem_wrdata);
        end
        tick();
        drive(1, 0, 0, 1, 0, 16'h0040, 0);
        n_tests++;
        if (bus.o_ldst_rdvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_rdvalid got %b want 0",
                     bus.o_ldst_rdvalid);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_ldst_rdvalid !== 1'b1 || bus.o_ldst_rddata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_readback v=%b d=%h want 1 beef",
                     bus.o_ldst_rdvalid, bus.o_ldst_rddata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 16'h0060, 1, 0, 16'h0160, 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 16'h0055, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_ldst_rdvalid !== 1'b0 || conflict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_clear v=%b cnt=%0d want 0 0",
                     bus.o_ldst_rdvalid, conflict_cnt);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 16'h0060, 1, 0, 16'h0160, 0);
            n_tests++;
            if (bus.o_ldst_rdvalid !== (i == 1) || bus.o_pc_rdvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_rdvalid[%0d] ld=%b pc=%b",
                         i, bus.o_ldst_rdvalid, bus.o_pc_rdvalid);
            end
            n_tests++;
            if (bus.o_mem_addr !== 16'h0160) begin
                n_fail++;
                $display("FAIL midrst_starve[%0d] addr=%h want 0160",
                         i, bus.o_mem_addr);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (conflict_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL midrst_conflict got %0d want 2", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        int          g;
        bit          prd;
        bit          lrd;
        bit          lwr;
        logic [15:0] exp_addr;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            prd = ($urandom_range(0, 3) != 0);
            lrd = ($urandom_range(0, 2) == 0);
            lwr = ($urandom_range(0, 3) == 0);
            drive(1, prd, 16'($urandom_range(0, 15)),
                  lrd, lwr, 16'($urandom_range(0, 15)),
                  16'($urandom));
            g = exp_grant();
            exp_addr = (g == 1) ? bus.i_pc_addr
                     : (g == 2) ? bus.i_ldst_addr : 16'h0000;
            n_tests++;
            if (bus.o_pc_waitreq !== (prd && g != 1)
                || bus.o_ldst_waitreq !== ((lrd || lwr) && g != 2)) begin
                n_fail++;
                $display("FAIL rnd_waitreq[%0d] pc=%b ld=%b grant=%0d",
                         i, bus.o_pc_waitreq, bus.o_ldst_waitreq, g);
            end
            n_tests++;
            if (bus.o_mem_addr !== exp_addr
                || bus.o_mem_rd !== (g == 1 || (g == 2 && !lwr))
                || bus.o_mem_wr !== (g == 2 && lwr)) begin
                n_fail++;
                $display("FAIL rnd_mem[%0d] a=%h rd=%b wr=%b want a=%h g=%0d",
                         i, bus.o_mem_addr, bus.o_mem_rd, bus.o_mem_wr,
                         exp_addr, g);
            end
            if (g != 1 && !(g == 2 && lwr)) begin
                n_tests++;
                if (bus.o_mem_wrdata !== 16'h0000 && g == 0) begin
                    n_fail++;
                    $display("FAIL rnd_wrdata_idle[%0d] got %h want 0000",
                             i, bus.o_mem_wrdata);
                end
            end else if (g == 2) begin
                n_tests++;
                if (bus.o_mem_wrdata !== bus.i_ldst_wrdata) begin
                    n_fail++;
                    $display("FAIL rnd_wrdata[%0d] got %h want %h",
                             i, bus.o_mem_wrdata, bus.i_ldst_wrdata);
                end
            end
            n_tests++;
            if (bus.o_pc_rdvalid !== m_pc_v || bus.o_ldst_rdvalid !== m_ld_v) begin
                n_fail++;
                $display("FAIL rnd_rdvalid[%0d] pc=%b ld=%b want %b %b",
                         i, bus.o_pc_rdvalid, bus.o_ldst_rdvalid,
                         m_pc_v, m_ld_v);
            end
            if (m_pc_v || m_ld_v) begin
                n_tests++;
                if ((m_pc_v && bus.o_pc_rddata !== m_data)
                    || (m_ld_v && bus.o_ldst_rddata !== m_data)) begin
                    n_fail++;
                    $display("FAIL rnd_rddata[%0d] pc=%h ld=%h want %h",
                             i, bus.o_pc_rddata, bus.o_ldst_rddata, m_data);
                end
            end
            n_tests++;
            if (conflict_cnt !== 16'(m_conf)) begin
                n_fail++;
                $display("FAIL rnd_conflict[%0d] got %0d want %0d",
                         i, conflict_cnt, m_conf);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            drive(1, 1, 16'h0070, 1, 0, 16'h0170, 0);
            if (i == 65534) begin
                n_tests++;
                if (conflict_cnt !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL sat_below got %h want fffe", conflict_cnt);
                end
            end
            if (i == 65535) begin
                n_tests++;
                if (conflict_cnt !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL sat_reach got %h want ffff", conflict_cnt);
                end
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold got %h want ffff", conflict_cnt);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            ram[i] = seed(i);
        reset             = 1'b0;
        bus.i_pc_rd       = 1'b0;
        bus.i_pc_addr     = 16'h0000;
        bus.i_ldst_rd     = 1'b0;
        bus.i_ldst_wr     = 1'b0;
        bus.i_ldst_addr   = 16'h0000;
        bus.i_ldst_wrdata = 16'h0000;
        model_clear();
        m_data = 16'h0000;

        test_reset();
        test_fetch_stream();
        test_conflict();
        test_starve();
        test_write();
        test_reset_mid_read();
        test_random();
        test_saturate();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
